uart_rx_fifo_less_os: RTL and testbench

- Self-timed UART receiver, 8N1, LSB first, idle-high line.
- Receive counterpart to the team's self-clocked transmitter: generates its own bit timing from CLKS_PER_BIT, so no external baud strobe is needed.
- Samples each bit at mid-bit with a 3-sample majority vote.
- Hands bytes to the fabric through a one-entry valid/ready holding register and flags framing errors and overruns.

---
 rtl/uart_rx_fifo_less_os_pkg.sv | 21 ++
 rtl/uart_rx_fifo_less_os_filter.sv | 30 +++
 rtl/uart_rx_fifo_less_os.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_fifo_less_os.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_less_os_pkg.sv
// Shared definitions for the self-timed UART receiver: state encoding,
// frame width, counter width and the majority-vote helper.
package uart_rx_fifo_less_os_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Two-of-three vote used to reject single-sample line glitches.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_less_os_filter.sv
// Line conditioning: two-flop synchronizer into a 3-sample history, with a
// majority vote for mid-bit sampling and the raw synchronized bit for edges.
module uart_rx_filter
  import uart_rx_fifo_less_os_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic serial,
  output logic sync_bit,
  output logic filt
);

  logic [1:0] r_sync;
  logic [2:0] r_hist;

  // Synchronize the async line and keep the last three samples; reset to idle-high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= 2'b11;
      r_hist <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], serial};
      r_hist <= {r_hist[1:0], r_sync[1]};
    end
  end

  assign sync_bit = r_sync[1];
  assign filt     = maj3(r_hist);

endmodule

// File: rtl/uart_rx_fifo_less_os.sv
// Self-timed 8N1 UART receiver with a one-entry valid/ready holding register.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for a low on the synchronized line
//   START    | timing to mid start bit, majority sample confirms the start
//   DATA     | sampling 8 data bits LSB first, one per CLKS_PER_BIT
//   STOP     | sampling the stop bit; high delivers, low flags framing error
//   BREAK    | line held low after a bad stop bit; wait for it to go high
module uart_rx_fifo_less_os
  import uart_rx_fifo_less_os_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       serial,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_rx_fifo_less_os: CLKS_PER_BIT must be >= 8");
  end

  localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] LP_BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LP_LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shreg;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_framing_error;
  logic             r_overrun;

  logic w_sync_bit;
  logic w_filt;
  logic w_cnt_clr;
  logic w_shift;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_deliver;
  logic w_consume;

  uart_rx_filter u_filter (
    .clk      (clk),
    .resetn   (resetn),
    .serial   (serial),
    .sync_bit (w_sync_bit),
    .filt     (w_filt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle sampling strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_sync_bit) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (r_cnt == LP_HALF_M1) begin
          if (w_filt) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (r_cnt == LP_BIT_M1) begin
          w_shift   = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_bitidx == LP_LAST_BIT) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == LP_BIT_M1) begin
          w_cnt_clr = 1'b1;
          if (w_filt) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_sync_bit) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else begin
      if (r_state == ST_IDLE || w_cnt_clr) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == ST_IDLE) r_bitidx <= '0;
      else if (w_shift)       r_bitidx <= r_bitidx + 3'd1;

      if (w_shift) r_shreg <= {w_filt, r_shreg[7:1]};
    end
  end

  // A same-cycle consume frees the holding register for the new byte.
  assign w_deliver = w_stop_ok && (!r_valid || ready);
  assign w_consume = r_valid && ready;

  // Holding register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_framing_error <= w_stop_bad;
      r_overrun       <= w_stop_ok && r_valid && !ready;
      if (w_deliver) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data          = r_data;
  assign valid         = r_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_less_os.sv
// Directed bench for the self-timed UART receiver at CLKS_PER_BIT=16.
module tb_uart_rx_fifo_less_os;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       serial = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo_less_os #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .serial        (serial),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  // Event log filled on the falling edge: new bytes, error pulses.
  logic [7:0] dq[$];
  int         tq[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         ov_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;

  initial forever begin
    @(negedge clk);
    if (valid === 1'b1 && (!prev_valid || prev_ready)) begin
      dq.push_back(data);
      tq.push_back(cyc);
    end
    if (framing_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    prev_valid = (valid === 1'b1);
    prev_ready = ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_log();
    dq.delete();
    tq.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    ov_cyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int t_start);
    t_start = cyc;
    serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      repeat (CPB) tick();
    end
    serial = stop_v;
    repeat (CPB) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(3);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (framing_error !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_flags got fe=%b ov=%b exp 0/0", framing_error, overrun);
    end
    resetn = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    ready = 1'b1;
    send_frame(8'h55, 1'b1, t0);
    idle(20);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", dq.size()); end
    if (dq.size() >= 1) begin
      checks++; if (dq[0] !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", dq[0]); end
      checks++; if (tq[0] - t0 !== 155) begin failures++; $display("FAIL single_latency got=%0d exp=155", tq[0] - t0); end
    end
    checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin failures++; $display("FAIL single_flags got fe=%0d ov=%0d exp 0/0", fe_cnt, ov_cnt); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", valid); end
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    clear_log();
    ready = 1'b1;
    send_frame(8'h00, 1'b1, ta);
    send_frame(8'hFF, 1'b1, tb);
    idle(20);
    checks++; if (dq.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", dq.size()); end
    if (dq.size() >= 2) begin
      checks++; if (dq[0] !== 8'h00) begin failures++; $display("FAIL b2b_first got=%h exp=00", dq[0]); end
      checks++; if (dq[1] !== 8'hFF) begin failures++; $display("FAIL b2b_second got=%h exp=ff", dq[1]); end
      checks++; if (tq[1] - tq[0] !== 160) begin failures++; $display("FAIL b2b_spacing got=%0d exp=160", tq[1] - tq[0]); end
    end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL b2b_framing got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_glitch();
    int lat;
    clear_log();
    serial = 1'b0;
    idle(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b exp=1", busy); end
    serial = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (lat < 0 && busy === 1'b0) lat = i;
    end
    checks++; if (lat < 1 || lat > HALF + 3) begin failures++; $display("FAIL glitch_busy_drop got=%0d exp=1..%0d", lat, HALF + 3); end
    checks++; if (dq.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin
      failures++; $display("FAIL glitch_quiet got bytes=%0d fe=%0d ov=%0d exp 0/0/0", dq.size(), fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_framing_break();
    int t0;
    clear_log();
    send_frame(8'hA3, 1'b0, t0);
    idle(40);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL break_fe_count got=%0d exp=1", fe_cnt); end
    checks++; if (dq.size() !== 0) begin failures++; $display("FAIL break_no_valid got=%0d exp=0", dq.size()); end
    serial = 1'b1;
    idle(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", busy); end
    send_frame(8'h3C, 1'b1, t0);
    idle(20);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL break_next_count got=%0d exp=1", dq.size()); end
    if (dq.size() >= 1) begin
      checks++; if (dq[0] !== 8'h3C) begin failures++; $display("FAIL break_next_data got=%h exp=3c", dq[0]); end
    end
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL break_fe_total got=%0d exp=1", fe_cnt); end
  endtask

  task automatic test_overrun();
    int t1, t2;
    clear_log();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, t1);
    send_frame(8'h22, 1'b1, t2);
    idle(20);
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    checks++; if (ov_cyc - t2 !== 155) begin failures++; $display("FAIL ovr_timing got=%0d exp=155", ov_cyc - t2); end
    checks++; if (valid !== 1'b1 || data !== 8'h11) begin failures++; $display("FAIL ovr_hold got v=%b d=%h exp v=1 d=11", valid, data); end
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL ovr_deliveries got=%0d exp=1", dq.size()); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_consume got=%b exp=0", valid); end
    idle(5);
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    logic [7:0] b;
    b = 8'h7E;
    clear_log();
    ready = 1'b1;
    serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      serial = b[i];
      repeat (CPB) tick();
    end
    serial = b[4];
    idle(8);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got=%b exp=1", busy); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || data !== 8'h00 || framing_error !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got v=%b b=%b d=%h fe=%b ov=%b exp all 0", valid, busy, data, framing_error, overrun);
    end
    serial = 1'b1;
    idle(200);
    checks++; if (dq.size() !== 0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_discard got bytes=%0d busy=%b exp 0/0", dq.size(), busy); end
    send_frame(8'h81, 1'b1, t0);
    idle(20);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", dq.size()); end
    if (dq.size() >= 1) begin
      checks++; if (dq[0] !== 8'h81) begin failures++; $display("FAIL rstmid_next_data got=%h exp=81", dq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_break();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
